// File: rtl/dct_butterfly_stage.sv
// First butterfly stage of an 8-point DCT: buffers one frame of x[0..7]
// and streams the four (x[i] + x[7-i], x[i] - x[7-i]) pairs downstream.
module dct_butterfly_stage #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   out_sum,
    output logic [DATA_W:0]   out_diff,
    output logic [1:0]        out_idx,
    output logic              out_last
);

    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [DATA_W:0] ONE = 1;

    state_t state_q;
    state_t state_d;

    logic [2:0] wr_cnt_q;
    logic [1:0] rd_cnt_q;

    logic [DATA_W-1:0] buf_q [8];

    logic in_hs;
    logic out_hs;
    logic frame_done;
    logic emit_done;

    logic [2:0] rd_lo;
    logic [2:0] rd_hi;
    logic [DATA_W:0] op_a;
    logic [DATA_W:0] op_b;
    logic [DATA_W:0] sum_w;
    logic [DATA_W:0] diff_w;

    assign in_hs      = in_valid & in_ready;
    assign out_hs     = out_valid & out_ready;
    assign frame_done = in_hs & (wr_cnt_q == 3'd7);
    assign emit_done  = out_hs & (rd_cnt_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD: if (frame_done) state_d = EMIT;
            EMIT: if (emit_done)  state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= 3'd0;
            rd_cnt_q <= 2'd0;
        end else begin
            if (in_hs) begin
                wr_cnt_q <= wr_cnt_q + 3'd1;
            end
            if (frame_done) begin
                rd_cnt_q <= 2'd0;
            end else if (out_hs) begin
                rd_cnt_q <= rd_cnt_q + 2'd1;
            end
        end
    end

    // in_ready is low in EMIT, so the frame is frozen while results drain.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            buf_q[wr_cnt_q] <= in_data;
        end
    end

    assign rd_lo = {1'b0, rd_cnt_q};
    assign rd_hi = 3'd7 - rd_lo;
    assign op_a  = {buf_q[rd_lo][DATA_W-1], buf_q[rd_lo]};
    assign op_b  = {buf_q[rd_hi][DATA_W-1], buf_q[rd_hi]};

    // One guard bit keeps both results exact for any pair of inputs.
    assign sum_w  = op_a + op_b;
    assign diff_w = op_a + ~op_b + ONE;

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_diff  = '0;
        out_idx   = 2'd0;
        out_last  = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_sum   = sum_w;
                out_diff  = diff_w;
                out_idx   = rd_cnt_q;
                out_last  = (rd_cnt_q == 2'd3);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dct_butterfly_stage.sv
// Scoreboard bench for dct_butterfly_stage: frames go in, expected
// butterfly pairs are queued, and drained results are checked in order.
module tb_dct_butterfly_stage;

    localparam int DATA_W = 16;

    typedef struct {
        int sum;
        int diff;
        int idx;
        bit last;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   out_sum;
    logic [DATA_W:0]   out_diff;
    logic [1:0]        out_idx;
    logic              out_last;

    int   n_cmp;
    int   n_err;
    int   frame [8];
    exp_t q [$];

    dct_butterfly_stage #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_diff  (out_diff),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int s_sum();
        return $signed(out_sum);
    endfunction

    function automatic int s_diff();
        return $signed(out_diff);
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.sum  = frame[i] + frame[7-i];
            e.diff = frame[i] - frame[7-i];
            e.idx  = i;
            e.last = (i == 3);
            q.push_back(e);
        end
    endtask

    // Called and returns just after a falling edge.
    task automatic send(input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = frame[i][DATA_W-1:0];
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL in_ready_load[%0d]: got %b want 1", i, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
            if (bubbles && i < n - 1) begin
                in_valid = 1'b0;
                in_data  = 16'hdead;
                @(posedge clk);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (n == 8) push_expected();
    endtask

    task automatic drain(input bit junk, input int stall_idx);
        exp_t e;
        int   t;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 20) begin
                @(posedge clk);
                @(negedge clk);
                t++;
            end
            n_cmp++;
            if (t == 20) begin
                n_err++;
                $display("FAIL out_valid_timeout[%0d]: got %b want 1", k, out_valid);
                return;
            end
            if (k == 0) begin
                n_cmp++;
                if (t != 0) begin
                    n_err++;
                    $display("FAIL latency: got %0d extra cycles want 0", t);
                end
            end
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty[%0d]: got 0 entries want >0", k);
                return;
            end
            e = q.pop_front();
            n_cmp++;
            if (s_sum() !== e.sum) begin
                n_err++;
                $display("FAIL out_sum[%0d]: got %0d want %0d", k, s_sum(), e.sum);
            end
            n_cmp++;
            if (s_diff() !== e.diff) begin
                n_err++;
                $display("FAIL out_diff[%0d]: got %0d want %0d", k, s_diff(), e.diff);
            end
            n_cmp++;
            if (int'(out_idx) !== e.idx || out_last !== e.last) begin
                n_err++;
                $display("FAIL idx_last[%0d]: got %0d/%b want %0d/%b",
                         k, out_idx, out_last, e.idx, e.last);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL in_ready_emit[%0d]: got %b want 0", k, in_ready);
            end
            if (junk) begin
                in_valid = 1'b1;
                in_data  = 16'd99;
            end
            if (k == stall_idx) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    @(negedge clk);
                    n_cmp++;
                    if (out_valid !== 1'b1 || s_sum() !== e.sum ||
                        s_diff() !== e.diff || int'(out_idx) !== e.idx ||
                        out_last !== e.last) begin
                        n_err++;
                        $display("FAIL stall_hold[%0d]: got v%b s%0d d%0d i%0d want v1 s%0d d%0d i%0d",
                                 k, out_valid, s_sum(), s_diff(), out_idx,
                                 e.sum, e.diff, e.idx);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
            out_diff !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_load: got r%b v%b s%0d d%0d i%0d l%b want r1 v0 zeros",
                     in_ready, out_valid, s_sum(), s_diff(), out_idx, out_last);
        end
    endtask

    task automatic set_frame(input int base, input int step);
        for (int i = 0; i < 8; i++) frame[i] = base + step * i;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #3;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
            out_diff !== '0 || out_idx !== 2'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got r%b v%b s%0d d%0d i%0d l%b want r1 v0 zeros",
                     in_ready, out_valid, out_sum, out_diff, out_idx, out_last);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        set_frame(1, 1);
        send(8, 1'b0);
        drain(1'b0, -1);
    endtask

    task automatic test_extremes();
        frame = '{32767, -32768, 0, 0, 0, 0, 32767, 32767};
        send(8, 1'b0);
        drain(1'b0, -1);
    endtask

    task automatic test_backpressure();
        set_frame(-300, 77);
        send(8, 1'b0);
        drain(1'b0, 1);
    endtask

    task automatic test_bubbles();
        set_frame(1, 1);
        send(8, 1'b1);
        drain(1'b0, -1);
    endtask

    task automatic test_reset_midframe();
        set_frame(1, 1);
        send(5, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midload: got r%b v%b want r1 v0", in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_frame(10, 10);
        send(8, 1'b0);
        drain(1'b0, -1);
    endtask

    task automatic test_reset_midemit();
        set_frame(5, -3);
        send(8, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 ||
            out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_midemit: got r%b v%b s%0d l%b want r1 v0 s0 l0",
                     in_ready, out_valid, out_sum, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_frame(10, 10);
        send(8, 1'b0);
        drain(1'b0, -1);
    endtask

    task automatic test_emit_ignore();
        set_frame(-4, 9);
        send(8, 1'b0);
        drain(1'b1, 2);
        set_frame(1, 1);
        send(8, 1'b0);
        drain(1'b0, -1);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) frame[i] = int'($urandom_range(0, 65535)) - 32768;
            send(8, 1'b0);
            drain(1'b0, -1);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_bubbles();
        test_reset_midframe();
        test_reset_midemit();
        test_emit_ignore();
        test_back_to_back();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
